glyph_plotter: RTL and testbench

Text-cell rendering sequencer for the notepad display path. The block accepts one character request at a time, drives the combinational character decoder with the code, and latches the returned 128-bit 8×16 glyph. It then streams the glyph as per-pixel writes, with a valid/ready handshake, to the 320×240 framebuffer/VGA adapter port. It sits between the editor text buffer controller and the pixel writer.

---
 rtl/glyph_plotter.sv | 130 +++++++++++++
 tb/tb_glyph_plotter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_plotter.sv
// Character cell renderer: latches a decoded 8x16 glyph and streams it as pixel writes.
// Define GLYPH_TRANSPARENT_EN to skip background pixels instead of plotting them in BG_COLOR.
//
// state  | meaning
// IDLE   | waiting for a character request, char_ready high
// LOAD   | decoder output settled, glyph captured, cell range checked
// DRAW   | presenting pixels 0..127 in raster order within the cell
// DONE   | one-cycle completion pulse
module glyph_plotter #(
  parameter logic [2:0] FG_COLOR = 3'b111,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         char_valid,
  input  logic [6:0]   char_code,
  input  logic [5:0]   char_col,
  input  logic [3:0]   char_row,
  output logic         char_ready,
  output logic [6:0]   dec_char,
  input  logic [127:0] dec_glyph,
  output logic [8:0]   pix_x,
  output logic [7:0]   pix_y,
  output logic [2:0]   pix_color,
  output logic         pix_plot,
  input  logic         pix_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     dec_char_q, dec_char_d;
  logic [5:0]     col_q, col_d;
  logic [3:0]     row_q, row_d;
  logic [127:0]   glyph_q, glyph_d;
  logic [6:0]     idx_q, idx_d;

  logic           in_draw;
  logic           pix_bit;
  logic           cell_oob;
  logic           advance;

  assign in_draw  = (state_q == S_DRAW);
  // Pixel i lives at glyph bit 127-i, which is the bitwise complement of a 7-bit index.
  assign pix_bit  = glyph_q[~idx_q];
  assign cell_oob = (col_q >= 6'd40) || (row_q >= 4'd15);

`ifdef GLYPH_TRANSPARENT_EN
  assign pix_plot  = in_draw & pix_bit;
  assign advance   = in_draw & (~pix_bit | pix_ready);
  assign pix_color = pix_plot ? FG_COLOR : 3'b000;
`else
  assign pix_plot  = in_draw;
  assign advance   = in_draw & pix_ready;
  assign pix_color = in_draw ? (pix_bit ? FG_COLOR : BG_COLOR) : 3'b000;
`endif

  // Cell origin is a multiple of 8/16, so the sums reduce to concatenations.
  assign pix_x      = in_draw ? {col_q, idx_q[2:0]} : 9'd0;
  assign pix_y      = in_draw ? {row_q, idx_q[6:3]} : 8'd0;

  assign char_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign dec_char   = dec_char_q;

  always_comb begin
    state_d    = state_q;
    dec_char_d = dec_char_q;
    col_d      = col_q;
    row_d      = row_q;
    glyph_d    = glyph_q;
    idx_d      = idx_q;
    case (state_q)
      S_IDLE: begin
        if (char_valid) begin
          dec_char_d = char_code;
          col_d      = char_col;
          row_d      = char_row;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        glyph_d = dec_glyph;
        idx_d   = 7'd0;
        state_d = cell_oob ? S_DONE : S_DRAW;
      end
      S_DRAW: begin
        if (advance) begin
          idx_d = idx_q + 7'd1;
          if (idx_q == 7'd127) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      dec_char_q <= 7'd32;
      col_q      <= 6'd0;
      row_q      <= 4'd0;
      glyph_q    <= 128'd0;
      idx_q      <= 7'd0;
    end else begin
      state_q    <= state_d;
      dec_char_q <= dec_char_d;
      col_q      <= col_d;
      row_q      <= row_d;
      glyph_q    <= glyph_d;
      idx_q      <= idx_d;
    end
  end

endmodule

// File: tb/tb_glyph_plotter.sv
// Directed bench for glyph_plotter with a small character ROM model acting as the decoder.
module tb_glyph_plotter;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         char_valid = 1'b0;
  logic [6:0]   char_code = 7'd0;
  logic [5:0]   char_col = 6'd0;
  logic [3:0]   char_row = 4'd0;
  logic         char_ready;
  logic [6:0]   dec_char;
  logic [127:0] dec_glyph;
  logic [8:0]   pix_x;
  logic [7:0]   pix_y;
  logic [2:0]   pix_color;
  logic         pix_plot;
  logic         pix_ready = 1'b1;
  logic         busy;
  logic         done;

`ifdef GLYPH_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int t0 = 0;

  glyph_plotter dut (
    .clk(clk), .resetn(resetn), .char_valid(char_valid), .char_code(char_code),
    .char_col(char_col), .char_row(char_row), .char_ready(char_ready),
    .dec_char(dec_char), .dec_glyph(dec_glyph), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .pix_plot(pix_plot), .pix_ready(pix_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] glyph_row(input logic [6:0] code, input int y);
    logic [7:0] r;
    r = 8'h00;
    case (code)
      7'd65: case (y)
        1: r = 8'h18;
        2: r = 8'h3C;
        3, 4, 5, 6, 8, 9, 10, 11, 12: r = 8'h66;
        7: r = 8'h7E;
        default: r = 8'h00;
      endcase
      7'd63: case (y)
        1: r = 8'h3C;
        2: r = 8'h66;
        3: r = 8'h06;
        4: r = 8'h0C;
        5, 6, 8, 9: r = 8'h18;
        default: r = 8'h00;
      endcase
      7'd46: case (y)
        7, 8: r = 8'h10;
        default: r = 8'h00;
      endcase
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] glyph_of(input logic [6:0] code);
    logic [127:0] g;
    g = '0;
    for (int y = 0; y < 16; y++) g[127 - 8*y -: 8] = glyph_row(code, y);
    return g;
  endfunction

  always_comb dec_glyph = glyph_of(dec_char);

  function automatic bit exp_bit(input logic [6:0] code, input int i);
    logic [7:0] r;
    r = glyph_row(code, i / 8);
    return r[7 - (i % 8)];
  endfunction

  // expected plot list
  logic [8:0] ex_x[0:127];
  logic [7:0] ex_y[0:127];
  logic [2:0] ex_c[0:127];
  int         ex_rel[0:127];
  int         ne;

  function automatic void build_exp(input logic [6:0] code, input int col, input int row);
    bit b;
    ne = 0;
    for (int i = 0; i < 128; i++) begin
      b = exp_bit(code, i);
      if (!TRANSP || b) begin
        ex_x[ne]   = 9'(col * 8 + i % 8);
        ex_y[ne]   = 8'(row * 16 + i / 8);
        ex_c[ne]   = b ? 3'd7 : 3'd0;
        ex_rel[ne] = 2 + i;
        ne++;
      end
    end
  endfunction

  // observed plot record
  logic [8:0] rx[0:511];
  logic [7:0] ry[0:511];
  logic [2:0] rc[0:511];
  bit         racc[0:511];
  int         rrel[0:511];
  int         n_pres, n_acc, done_rel, done_cnt, rdy_busy_cnt, busy_low_cnt;
  bit         timeout, rdy_after;

  task automatic do_accept(input logic [6:0] code, input int col, input int row, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    char_valid = 1'b1;
    char_code  = code;
    char_col   = 6'(col);
    char_row   = 4'(row);
    for (int w = 0; w < 400; w++) begin
      if (char_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      t0 = cyc;
    end
    char_valid = 1'b0;
  endtask

  task automatic collect(input bit toggle);
    int rel;
    n_pres = 0; n_acc = 0; done_rel = -1; done_cnt = 0;
    rdy_busy_cnt = 0; busy_low_cnt = 0; timeout = 1'b1; rdy_after = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      rel = cyc - t0 + 1;
      if (done_rel >= 0) begin
        rdy_after = char_ready;
        timeout = 1'b0;
        break;
      end
      pix_ready = toggle ? rel[0] : 1'b1;
      if (pix_plot && n_pres < 512) begin
        rx[n_pres] = pix_x; ry[n_pres] = pix_y; rc[n_pres] = pix_color;
        racc[n_pres] = pix_ready; rrel[n_pres] = rel;
        if (pix_ready) n_acc++;
        n_pres++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end else begin
        if (char_ready) rdy_busy_cnt++;
        if (!busy) busy_low_cnt++;
      end
    end
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    nvec++; if (char_ready !== 1'b1) begin nerr++; $display("FAIL rst_char_ready got %b want 1", char_ready); end
    nvec++; if (dec_char !== 7'd32) begin nerr++; $display("FAIL rst_dec_char got %0d want 32", dec_char); end
    nvec++; if ({pix_x, pix_y, pix_color} !== 20'd0) begin nerr++; $display("FAIL rst_pix got x=%0d y=%0d c=%0d want 0", pix_x, pix_y, pix_color); end
    nvec++; if ({pix_plot, busy, done} !== 3'b000) begin nerr++; $display("FAIL rst_flags got plot/busy/done=%b%b%b want 000", pix_plot, busy, done); end
  endtask

  task automatic test_char_a();
    bit ok, shown;
    int k;
    do_accept(7'd65, 0, 0, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL a_accept got %b want 1", ok); end
    nvec++; if (dec_char !== 7'd65) begin nerr++; $display("FAIL a_dec_char got %0d want 65", dec_char); end
    collect(1'b0);
    build_exp(7'd65, 0, 0);
    nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL a_timeout got %b want 0", timeout); end
    nvec++; if (n_pres !== ne) begin nerr++; $display("FAIL a_plot_count got %0d want %0d", n_pres, ne); end
    k = 0; shown = 1'b0;
    for (int j = 0; j < n_pres && k < ne; j++) begin
      if (racc[j]) begin
        nvec++;
        if (rx[j] !== ex_x[k] || ry[j] !== ex_y[k] || rc[j] !== ex_c[k] || rrel[j] !== ex_rel[k]) begin
          nerr++;
          if (!shown) $display("FAIL a_pixel[%0d] got (%0d,%0d,c%0d,T%0d) want (%0d,%0d,c%0d,T%0d)",
                               k, rx[j], ry[j], rc[j], rrel[j], ex_x[k], ex_y[k], ex_c[k], ex_rel[k]);
          shown = 1'b1;
        end
        k++;
      end
    end
`ifndef GLYPH_TRANSPARENT_EN
    nvec++; if (rc[0] !== 3'd0) begin nerr++; $display("FAIL a_px_0_0 got %0d want 0", rc[0]); end
    nvec++; if (rc[11] !== 3'd7) begin nerr++; $display("FAIL a_px_3_1 got %0d want 7", rc[11]); end
    nvec++; if (rc[12] !== 3'd7) begin nerr++; $display("FAIL a_px_4_1 got %0d want 7", rc[12]); end
    nvec++; if (rc[57] !== 3'd7) begin nerr++; $display("FAIL a_px_1_7 got %0d want 7", rc[57]); end
    nvec++; if (rc[120] !== 3'd0) begin nerr++; $display("FAIL a_px_0_15 got %0d want 0", rc[120]); end
`endif
    nvec++; if (done_rel !== 130) begin nerr++; $display("FAIL a_done_time got T%0d want T130", done_rel); end
    nvec++; if (rdy_after !== 1'b1) begin nerr++; $display("FAIL a_ready_T131 got %b want 1", rdy_after); end
    nvec++; if (rdy_busy_cnt !== 0) begin nerr++; $display("FAIL a_ready_while_busy got %0d cycles want 0", rdy_busy_cnt); end
    nvec++; if (busy_low_cnt !== 0) begin nerr++; $display("FAIL a_busy_low got %0d cycles want 0", busy_low_cnt); end
  endtask

  task automatic test_stall();
    bit ok, shown;
    int k;
    do_accept(7'd65, 0, 0, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL st_accept got %b want 1", ok); end
    collect(1'b1);
    build_exp(7'd65, 0, 0);
    nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL st_timeout got %b want 0", timeout); end
    nvec++; if (n_acc !== ne) begin nerr++; $display("FAIL st_accept_count got %0d want %0d", n_acc, ne); end
    k = 0; shown = 1'b0;
    for (int j = 0; j < n_pres && k < ne; j++) begin
      if (racc[j]) begin
        nvec++;
        if (rx[j] !== ex_x[k] || ry[j] !== ex_y[k] || rc[j] !== ex_c[k]) begin
          nerr++;
          if (!shown) $display("FAIL st_pixel[%0d] got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                               k, rx[j], ry[j], rc[j], ex_x[k], ex_y[k], ex_c[k]);
          shown = 1'b1;
        end
        k++;
      end
    end
    shown = 1'b0;
    for (int j = 0; j < n_pres - 1; j++) begin
      if (!racc[j]) begin
        nvec++;
        if (rx[j+1] !== rx[j] || ry[j+1] !== ry[j] || rc[j+1] !== rc[j] || rrel[j+1] !== rrel[j] + 1) begin
          nerr++;
          if (!shown) $display("FAIL st_hold at T%0d got (%0d,%0d,c%0d,T%0d) want (%0d,%0d,c%0d,T%0d)",
                               rrel[j], rx[j+1], ry[j+1], rc[j+1], rrel[j+1], rx[j], ry[j], rc[j], rrel[j] + 1);
          shown = 1'b1;
        end
      end
    end
    nvec++; if (done_rel !== 130 + (n_pres - n_acc)) begin nerr++; $display("FAIL st_done_time got T%0d want T%0d", done_rel, 130 + (n_pres - n_acc)); end
    nvec++; if (done_cnt !== 1) begin nerr++; $display("FAIL st_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_corner_and_back_to_back();
    bit ok, shown;
    int k, bad;
    do_accept(7'd63, 39, 14, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL cn_accept got %b want 1", ok); end
    fork
      collect(1'b0);
      begin
        repeat (10) @(negedge clk);
        char_valid = 1'b1; char_code = 7'd65; char_col = 6'd0; char_row = 4'd0;
      end
    join
    build_exp(7'd63, 39, 14);
    nvec++; if (n_pres !== ne) begin nerr++; $display("FAIL cn_plot_count got %0d want %0d", n_pres, ne); end
    k = 0; shown = 1'b0; bad = 0;
    for (int j = 0; j < n_pres && k < ne; j++) begin
      if (rx[j] < 9'd312 || rx[j] > 9'd319 || ry[j] < 8'd224 || ry[j] > 8'd239) bad++;
      nvec++;
      if (rx[j] !== ex_x[k] || ry[j] !== ex_y[k] || rc[j] !== ex_c[k]) begin
        nerr++;
        if (!shown) $display("FAIL cn_pixel[%0d] got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                             k, rx[j], ry[j], rc[j], ex_x[k], ex_y[k], ex_c[k]);
        shown = 1'b1;
      end
      k++;
    end
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL cn_range got %0d out-of-cell plots want 0", bad); end
    nvec++; if (done_rel !== 130) begin nerr++; $display("FAIL cn_done_time got T%0d want T130", done_rel); end
    nvec++; if (rdy_busy_cnt !== 0) begin nerr++; $display("FAIL b2b_ready_while_busy got %0d want 0", rdy_busy_cnt); end
    nvec++; if (dec_char !== 7'd63) begin nerr++; $display("FAIL b2b_not_consumed got dec_char %0d want 63", dec_char); end
    nvec++; if (rdy_after !== 1'b1) begin nerr++; $display("FAIL b2b_ready_T131 got %b want 1", rdy_after); end
    @(posedge clk);
    #1;
    t0 = cyc;
    char_valid = 1'b0;
    nvec++; if (dec_char !== 7'd65) begin nerr++; $display("FAIL b2b_second_accept got dec_char %0d want 65", dec_char); end
    collect(1'b0);
    build_exp(7'd65, 0, 0);
    nvec++; if (n_pres !== ne) begin nerr++; $display("FAIL b2b_plot_count got %0d want %0d", n_pres, ne); end
    nvec++; if (n_pres > 0 && (rx[0] !== ex_x[0] || ry[0] !== ex_y[0] || rc[0] !== ex_c[0])) begin
      nerr++; $display("FAIL b2b_first_pixel got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", rx[0], ry[0], rc[0], ex_x[0], ex_y[0], ex_c[0]);
    end
    nvec++; if (done_rel !== 130) begin nerr++; $display("FAIL b2b_done_time got T%0d want T130", done_rel); end
  endtask

  task automatic test_out_of_range();
    bit ok;
    do_accept(7'd65, 40, 0, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL oob_col_accept got %b want 1", ok); end
    collect(1'b0);
    nvec++; if (n_pres !== 0) begin nerr++; $display("FAIL oob_col_plots got %0d want 0", n_pres); end
    nvec++; if (done_rel !== 2) begin nerr++; $display("FAIL oob_col_done got T%0d want T2", done_rel); end
    nvec++; if (rdy_after !== 1'b1) begin nerr++; $display("FAIL oob_col_ready_T3 got %b want 1", rdy_after); end
    do_accept(7'd65, 0, 15, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL oob_row_accept got %b want 1", ok); end
    collect(1'b0);
    nvec++; if (n_pres !== 0) begin nerr++; $display("FAIL oob_row_plots got %0d want 0", n_pres); end
    nvec++; if (done_rel !== 2) begin nerr++; $display("FAIL oob_row_done got T%0d want T2", done_rel); end
  endtask

  task automatic test_dot();
    bit ok;
    do_accept(7'd46, 0, 0, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL dot_accept got %b want 1", ok); end
    collect(1'b0);
`ifdef GLYPH_TRANSPARENT_EN
    nvec++; if (n_pres !== 2) begin nerr++; $display("FAIL dot_plot_count got %0d want 2", n_pres); end
    nvec++; if (n_pres > 0 && {rx[0], ry[0], rc[0]} !== {9'd3, 8'd7, 3'd7}) begin
      nerr++; $display("FAIL dot_plot0 got (%0d,%0d,c%0d) want (3,7,c7)", rx[0], ry[0], rc[0]);
    end
    nvec++; if (n_pres > 1 && {rx[1], ry[1], rc[1]} !== {9'd3, 8'd8, 3'd7}) begin
      nerr++; $display("FAIL dot_plot1 got (%0d,%0d,c%0d) want (3,8,c7)", rx[1], ry[1], rc[1]);
    end
`else
    nvec++; if (n_pres !== 128) begin nerr++; $display("FAIL dot_plot_count got %0d want 128", n_pres); end
    nvec++; if ({rc[58], rc[59], rc[67], rc[68]} !== {3'd0, 3'd7, 3'd7, 3'd0}) begin
      nerr++; $display("FAIL dot_colors got %0d/%0d/%0d/%0d want 0/7/7/0", rc[58], rc[59], rc[67], rc[68]);
    end
`endif
    nvec++; if (done_rel !== 130) begin nerr++; $display("FAIL dot_done_time got T%0d want T130", done_rel); end
  endtask

  task automatic test_reset_mid_draw();
    bit ok, shown;
    int k;
    do_accept(7'd65, 0, 0, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL mr_accept got %b want 1", ok); end
    pix_ready = 1'b1;
    repeat (50) @(negedge clk);
    nvec++; if (pix_plot !== 1'b1) begin nerr++; $display("FAIL mr_drawing_T50 got plot %b want 1", pix_plot); end
    resetn = 1'b0;
    #1;
    nvec++; if ({pix_plot, busy, char_ready} !== 3'b001) begin
      nerr++; $display("FAIL mr_async_drop got plot/busy/ready=%b%b%b want 001", pix_plot, busy, char_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nvec++; if ({pix_plot, done} !== 2'b00) begin nerr++; $display("FAIL mr_in_reset got plot/done=%b%b want 00", pix_plot, done); end
    end
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nvec++; if ({pix_plot, done, char_ready} !== 3'b001) begin
        nerr++; $display("FAIL mr_after_release got plot/done/ready=%b%b%b want 001", pix_plot, done, char_ready);
      end
    end
    nvec++; if (dec_char !== 7'd32) begin nerr++; $display("FAIL mr_dec_char got %0d want 32", dec_char); end
    do_accept(7'd65, 2, 3, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL mr_reaccept got %b want 1", ok); end
    collect(1'b0);
    build_exp(7'd65, 2, 3);
    nvec++; if (n_pres !== ne) begin nerr++; $display("FAIL mr_plot_count got %0d want %0d", n_pres, ne); end
    k = 0; shown = 1'b0;
    for (int j = 0; j < n_pres && k < ne; j++) begin
      nvec++;
      if (rx[j] !== ex_x[k] || ry[j] !== ex_y[k] || rc[j] !== ex_c[k] || rrel[j] !== ex_rel[k]) begin
        nerr++;
        if (!shown) $display("FAIL mr_pixel[%0d] got (%0d,%0d,c%0d,T%0d) want (%0d,%0d,c%0d,T%0d)",
                             k, rx[j], ry[j], rc[j], rrel[j], ex_x[k], ex_y[k], ex_c[k], ex_rel[k]);
        shown = 1'b1;
      end
      k++;
    end
    nvec++; if (done_rel !== 130) begin nerr++; $display("FAIL mr_done_time got T%0d want T130", done_rel); end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    test_reset();
    test_char_a();
    test_stall();
    test_corner_and_back_to_back();
    test_out_of_range();
    test_dot();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1);
  end

endmodule
